d_pipe_reg: RTL and testbench

Parametrised, multi-stage storage pipeline that extends the team's single-bit D storage element. It adds configurable data width, configurable stage depth, a valid/ready handshake with bubble collapsing, a synchronous flush and an occupancy count. It sits between producer and consumer blocks that need a registered, back-pressurable delay line of fixed maximum latency.

---
 rtl/d_pipe_reg.sv | 116 +++++++++++
 tb/tb_d_pipe_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/d_pipe_reg.sv
// d_pipe_reg: parametrised multi-stage storage pipeline.
// Each stage holds a data word and a valid bit. A stage advances whenever the
// next stage is empty or itself advancing, so bubbles collapse toward the
// output. Synchronous flush clears all stages; count tracks occupied stages.
// Optional build macro PIPE_PARITY_EN adds a per-stage parity bit and drives
// out_perr; without it out_perr is tied low and the port list is unchanged.
module d_pipe_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             out_perr
);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic             accept;
  logic             take;
  logic [CW-1:0]    count_nxt;

  // Advance chain: built from the output stage back toward the input stage.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = !v[DEPTH-1] || out_ready;
    adv[DEPTH-1] = chain;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      chain = !v[DEPTH-1-k] || chain;
      adv[DEPTH-1-k] = chain;
    end
  end

  // Handshake decode; in_ready is held high while rst is asserted so the
  // producer sees a ready pipeline during reset (accepts are discarded).
  always_comb begin
    in_ready  = (adv[0] || rst) && !flush;
    accept    = in_valid && in_ready;
    take      = v[DEPTH-1] && out_ready;
    out_valid = v[DEPTH-1];
    out_data  = d[DEPTH-1];
  end

  // Occupancy next value: +1 on accept only, -1 on take only.
  always_comb begin
    count_nxt = count;
    if (accept && !take) begin
      count_nxt = count + CW'(1);
    end else if (take && !accept) begin
      count_nxt = count - CW'(1);
    end
  end

  // Stage registers, valid bits and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
      v     <= '0;
      count <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= accept;
        if (accept) begin
          d[0] <= in_data;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          d[i] <= d[i-1];
          v[i] <= v[i-1];
        end
      end
      count <= count_nxt;
    end
  end

`ifdef PIPE_PARITY_EN
  logic [DEPTH-1:0] p;

  // Parity bits travel alongside their data words.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      p <= '0;
    end else begin
      if (adv[0] && accept) begin
        p[0] <= ^in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          p[i] <= p[i-1];
        end
      end
    end
  end

  // Parity check on the output stage, qualified by out_valid.
  always_comb begin
    out_perr = v[DEPTH-1] && ((^d[DEPTH-1]) != p[DEPTH-1]);
  end
`else
  assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_d_pipe_reg.sv
// tb_d_pipe_reg: directed table-driven bench for d_pipe_reg (WIDTH=8, DEPTH=4),
// plus hand-written flush and mid-stream reset sequences.
module tb_d_pipe_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       out_perr;

  int unsigned n_pass;
  int unsigned n_total;

  d_pipe_reg #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .out_perr(out_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       chk_od;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic iv, logic [7:0] din, logic ordy,
                              logic e_ir, logic e_ov, logic [7:0] e_od,
                              logic chk_od, logic [2:0] e_cnt);
    vec_t t;
    t.rst = r; t.iv = iv; t.din = din; t.ordy = ordy;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.chk_od = chk_od; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [7:0] din, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = din; out_ready = ordy;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset; second reset cycle offers a word that must be ignored.
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 8'hEE, 1, 1, 0, 8'h00, 1, 0));
    // Back-to-back 0x11/0x22/0x33, out_ready=1.
    tbl.push_back(mk(0, 1, 8'h11, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 8'h22, 1, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(0, 1, 8'h33, 1, 1, 0, 8'h00, 0, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
    // Fill with out_ready=0: 0x01..0x04 accepted, 0x05 blocked.
    tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 8'h02, 0, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(0, 1, 8'h03, 0, 1, 0, 8'h00, 0, 3));
    tbl.push_back(mk(0, 1, 8'h04, 0, 1, 1, 8'h01, 1, 4));
    tbl.push_back(mk(0, 1, 8'h05, 0, 0, 1, 8'h01, 1, 4));
    tbl.push_back(mk(0, 1, 8'h05, 0, 0, 1, 8'h01, 1, 4));
    // Release: 0x05, 0x06 enter as 0x01, 0x02 leave.
    tbl.push_back(mk(0, 1, 8'h05, 1, 1, 1, 8'h02, 1, 4));
    tbl.push_back(mk(0, 1, 8'h06, 1, 1, 1, 8'h03, 1, 4));
    // Full pipe, accept and take every cycle for 10 cycles.
    for (int n = 0; n < 10; n++) begin
      logic [7:0] din;
      logic [7:0] eod;
      din = 8'h80 + 8'(n);
      eod = (n < 3) ? 8'h04 + 8'(n) : 8'h80 + 8'(n - 3);
      tbl.push_back(mk(0, 1, din, 1, 1, 1, eod, 1, 4));
    end
    // Drain: 0x86 was at the output; 0x87..0x89 follow.
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h87, 1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h88, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h89, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
    // Bubble collapse: 0xA0, 2 idle, 0xA1, out_ready=0.
    tbl.push_back(mk(0, 1, 8'hA0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 1, 1, 8'hA0, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'hA0, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'hA0, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'hA0, 1, 2));
    // 0xA1 must be in stage 2: it reaches the output one edge after the take.
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, 1'b0, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("v%0d_out_perr", i), out_perr, 0);
      if (tbl[i].chk_od) check($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
    end

    // Flush with count=3 while 0x55 is offered.
    drive(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0); step();
    drive(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0); step();
    drive(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0); step();
    check("pre_flush_count", count, 3);
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("post_flush_count", count, 0);
    check("post_flush_out_valid", out_valid, 0);

    // Reset with a full, stalled pipe.
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b0, 1'b1, 8'hD0 + 8'(n), 1'b0);
      step();
    end
    check("pre_rst_count", count, 4);
    check("pre_rst_out_data", out_data, 8'hD0);
    drive(1'b1, 1'b0, 1'b1, 8'hE7, 1'b0);
    #1;
    check("rst_in_ready", in_ready, 1);
    step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_perr", out_perr, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check("post_rst_count", count, 0);
    check("post_rst_out_valid", out_valid, 0);

    // Clean word travels through with no parity error in either build.
    drive(1'b0, 1'b0, 1'b1, 8'h0F, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(); step(); step();
    check("parity_word_valid", out_valid, 1);
    check("parity_word_data", out_data, 8'h0F);
    check("parity_word_perr", out_perr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
